// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// imem_req/imem_addr stay stable from issue until the cycle imem_ack is high.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: samples IP, runs a req/ack memory fetch, holds the
// word for decode, drops work on FLUSH and aborts requests memory never answers.
module ifetch_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   IP,
  input  logic          FLUSH,
  input  logic          dec_ready,
  ifetch_unit_if.master imem,
  output logic [31:0]   INSTR,
  output logic [6:0]    OP,
  output logic          instr_valid,
  output logic          fetch_stall,
  output logic [31:0]   fetch_count,
  output logic          fetch_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  state_t      r_state, w_state_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_err, w_err_nxt;
  logic [15:0] r_to, w_to_nxt;
  logic        w_stall;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= 32'd0;
      r_instr <= NOP;
      r_valid <= 1'b0;
      r_count <= 32'd0;
      r_err   <= 1'b0;
      r_to    <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_to    <= w_to_nxt;
    end
  end

  // Decode handshake: a word transfers on a cycle where instr_valid && dec_ready && !FLUSH;
  // once valid is high, INSTR stays unchanged until that transfer or a flush.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_to_nxt    = r_to;
    w_stall     = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_to_nxt = 16'd0;
        if (!FLUSH) begin
          w_stall     = 1'b0;
          w_addr_nxt  = IP;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end

      S_REQ, S_DROP: begin
        if (imem.imem_ack) begin
          w_to_nxt  = 16'd0;
          w_req_nxt = 1'b0;
          if (r_state == S_REQ && !FLUSH) begin
            w_instr_nxt = imem.imem_rdata;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_to == TO_LAST) begin
          // Abort wins over a same-cycle flush; both end in IDLE anyway.
          w_err_nxt   = 1'b1;
          w_req_nxt   = 1'b0;
          w_valid_nxt = 1'b0;
          w_to_nxt    = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_nxt = r_to + 16'd1;
          if (FLUSH) begin
            w_state_nxt = S_DROP;
          end
        end
      end

      S_HOLD: begin
        w_to_nxt = 16'd0;
        if (FLUSH) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (dec_ready) begin
          w_stall     = 1'b0;
          w_count_nxt = r_count + 32'd1;
          w_valid_nxt = 1'b0;
          w_addr_nxt  = IP;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign INSTR          = r_instr;
  assign OP             = r_instr[6:0];
  assign instr_valid    = r_valid;
  assign fetch_stall    = w_stall;
  assign fetch_count    = r_count;
  assign fetch_err      = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, free-run, wait states, back-pressure, flushes,
// timeout and reset over an outstanding request, with hand-computed expectations.
module tb_ifetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IP;
  logic        FLUSH;
  logic        dec_ready;
  logic [31:0] INSTR;
  logic [6:0]  OP;
  logic        instr_valid;
  logic        fetch_stall;
  logic [31:0] fetch_count;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  ifetch_unit_if imem_bus ();

  ifetch_unit #(.TIMEOUT(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IP          (IP),
    .FLUSH       (FLUSH),
    .dec_ready   (dec_ready),
    .imem        (imem_bus),
    .INSTR       (INSTR),
    .OP          (OP),
    .instr_valid (instr_valid),
    .fetch_stall (fetch_stall),
    .fetch_count (fetch_count),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp);
    n_vec++;
    assert (dbg_state === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  initial begin
    RESET = 1'b0;
    IP = 32'h0;
    FLUSH = 1'b0;
    dec_ready = 1'b0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    // Reset for two edges
    tick();
    tick();
    chk1("rst_req", imem_bus.imem_req, 1'b0);
    chk32("rst_addr", imem_bus.imem_addr, 32'h0);
    chk32("rst_instr", INSTR, 32'h0000_0013);
    chk32("rst_op", {25'd0, OP}, 32'h13);
    chk1("rst_valid", instr_valid, 1'b0);
    chk32("rst_count", fetch_count, 32'h0);
    chk1("rst_err", fetch_err, 1'b0);
    chk_st("rst_state", ST_IDLE);

    // Free-run, zero-wait memory
    RESET = 1'b1;
    dec_ready = 1'b1;
    #1;
    chk1("idle_stall", fetch_stall, 1'b0);
    tick();
    chk1("fr_req", imem_bus.imem_req, 1'b1);
    chk32("fr_addr", imem_bus.imem_addr, 32'h0);
    chk1("fr_req_stall", fetch_stall, 1'b1);
    chk1("fr_valid_early", instr_valid, 1'b0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0050_0093;
    tick();
    imem_bus.imem_ack = 1'b0;
    IP = 32'h4;
    #1;
    chk1("fr_valid", instr_valid, 1'b1);
    chk32("fr_instr", INSTR, 32'h0050_0093);
    chk32("fr_op", {25'd0, OP}, 32'h13);
    chk1("fr_req_drop", imem_bus.imem_req, 1'b0);
    chk1("fr_hold_stall", fetch_stall, 1'b0);
    tick();
    chk32("fr_count", fetch_count, 32'd1);
    chk1("fr_valid_clr", instr_valid, 1'b0);
    chk1("fr_req2", imem_bus.imem_req, 1'b1);
    chk32("fr_addr2", imem_bus.imem_addr, 32'h4);

    // Three wait states before ack
    for (int i = 0; i < 3; i++) begin
      chk1("ws_req", imem_bus.imem_req, 1'b1);
      chk32("ws_addr", imem_bus.imem_addr, 32'h4);
      chk1("ws_stall", fetch_stall, 1'b1);
      chk1("ws_valid", instr_valid, 1'b0);
      tick();
    end
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h00A0_0113;
    #1;
    chk1("ws_ack_req", imem_bus.imem_req, 1'b1);
    chk1("ws_ack_valid", instr_valid, 1'b0);
    tick();
    imem_bus.imem_ack = 1'b0;
    chk1("ws_valid_after", instr_valid, 1'b1);
    chk32("ws_instr", INSTR, 32'h00A0_0113);
    chk1("ws_err", fetch_err, 1'b0);

    // Decode back-pressure for 4 cycles
    dec_ready = 1'b0;
    IP = 32'h8;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1("bp_stall", fetch_stall, 1'b1);
      chk32("bp_instr", INSTR, 32'h00A0_0113);
      chk1("bp_req", imem_bus.imem_req, 1'b0);
      chk1("bp_valid", instr_valid, 1'b1);
      chk32("bp_count", fetch_count, 32'd1);
      tick();
    end
    dec_ready = 1'b1;
    #1;
    chk1("bp_release_stall", fetch_stall, 1'b0);
    tick();
    chk32("bp_count_inc", fetch_count, 32'd2);
    chk1("bp_req_new", imem_bus.imem_req, 1'b1);
    chk32("bp_addr_new", imem_bus.imem_addr, 32'h8);

    // Flush in REQ cycle 1, ack in cycle 3
    FLUSH = 1'b1;
    IP = 32'h40;
    tick();
    FLUSH = 1'b0;
    chk_st("fl_drop_state", ST_DROP);
    chk1("fl_drop_req", imem_bus.imem_req, 1'b1);
    chk32("fl_drop_addr", imem_bus.imem_addr, 32'h8);
    chk1("fl_drop_stall", fetch_stall, 1'b1);
    tick();
    chk1("fl_valid_c2", instr_valid, 1'b0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk1("fl_req_done", imem_bus.imem_req, 1'b0);
    chk1("fl_valid", instr_valid, 1'b0);
    chk32("fl_instr_kept", INSTR, 32'h00A0_0113);
    chk_st("fl_idle", ST_IDLE);
    chk1("fl_idle_stall", fetch_stall, 1'b0);
    tick();
    chk1("fl_next_req", imem_bus.imem_req, 1'b1);
    chk32("fl_next_addr", imem_bus.imem_addr, 32'h40);

    // Flush and ready together in HOLD
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0040_006F;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk1("fr2_valid", instr_valid, 1'b1);
    chk32("fr2_op", {25'd0, OP}, 32'h6F);
    FLUSH = 1'b1;
    IP = 32'h80;
    #1;
    chk1("fvr_stall", fetch_stall, 1'b1);
    tick();
    chk1("fvr_valid", instr_valid, 1'b0);
    chk32("fvr_count", fetch_count, 32'd2);
    chk1("fvr_req", imem_bus.imem_req, 1'b0);
    chk_st("fvr_state", ST_IDLE);
    // FLUSH held in IDLE keeps the unit idle
    chk1("fidle_stall", fetch_stall, 1'b1);
    tick();
    FLUSH = 1'b0;
    chk1("fidle_req", imem_bus.imem_req, 1'b0);
    chk_st("fidle_state", ST_IDLE);
    tick();
    chk1("fidle_next_req", imem_bus.imem_req, 1'b1);
    chk32("fidle_next_addr", imem_bus.imem_addr, 32'h80);

    // Timeout with TIMEOUT=4 and no ack
    tick();
    tick();
    tick();
    chk1("to_req_c4", imem_bus.imem_req, 1'b1);
    chk1("to_err_c4", fetch_err, 1'b0);
    tick();
    chk1("to_err", fetch_err, 1'b1);
    chk1("to_req", imem_bus.imem_req, 1'b0);
    chk1("to_valid", instr_valid, 1'b0);
    chk_st("to_state", ST_IDLE);
    IP = 32'hC0;
    tick();
    chk1("to_resume_req", imem_bus.imem_req, 1'b1);
    chk32("to_resume_addr", imem_bus.imem_addr, 32'hC0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h00C0_0193;
    tick();
    imem_bus.imem_ack = 1'b0;
    IP = 32'h100;
    chk32("to_resume_instr", INSTR, 32'h00C0_0193);
    chk1("to_err_sticky", fetch_err, 1'b1);
    tick();
    chk32("to_count", fetch_count, 32'd3);
    chk32("to_addr_next", imem_bus.imem_addr, 32'h100);

    // Reset over an outstanding request, then a late ack
    RESET = 1'b0;
    tick();
    chk1("rr_req", imem_bus.imem_req, 1'b0);
    chk1("rr_err", fetch_err, 1'b0);
    chk32("rr_count", fetch_count, 32'd0);
    chk32("rr_addr", imem_bus.imem_addr, 32'h0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk1("rr_late_valid", instr_valid, 1'b0);
    chk32("rr_late_instr", INSTR, 32'h0000_0013);
    RESET = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end between the program counter and decode. Each cycle it is free, it samples the fetch address `IP`, issues a request to instruction memory over a req/ack handshake, and captures the returned word. It presents the word to decode with a valid/ready handshake. It back-pressures the program counter with `fetch_stall`. It discards in-flight or held instructions on a branch/jump redirect (`FLUSH`), and flags a memory that never acknowledges.

## Interface
- `TIMEOUT`, default 255: cycles with `imem_req` high and no `imem_ack` before abort; legal range 1..65535.
- `CLK` in 1: clock, all state updates on rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `IP` in 32: current fetch address from the program counter.
- `FLUSH` in 1: redirect; discard any outstanding or held instruction.
- `dec_ready` in 1: decode accepts the presented instruction this cycle.
- `imem_ack` in 1: memory has placed the word on `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word, valid only when `imem_ack`=1.
- `imem_req` out 1: registered; request outstanding.
- `imem_addr` out 32: registered; address of outstanding request.
- `INSTR` out 32: registered; instruction presented to decode.
- `OP` out 7: `INSTR[6:0]`.
- `instr_valid` out 1: registered; `INSTR` is valid.
- `fetch_stall` out 1: combinational; the program counter must hold `IP` this cycle.
- `fetch_count` out 32: registered; instructions accepted by decode.
- `fetch_err` out 1: registered, sticky; set on timeout.

## Operation
- **Reset values:**
  - `imem_req`=0, `imem_addr`=0.
  - `INSTR`=32'h00000013 (NOP), so `OP`=7'b0010011.
  - `instr_valid`=0, `fetch_count`=0, `fetch_err`=0.
  - State IDLE; timeout counter 0.
- **IDLE:**
  - If `FLUSH`=0: `imem_addr`<=`IP`, `imem_req`<=1, go to REQ.
  - If `FLUSH`=1: stay IDLE, no request, so the redirected `IP` is sampled next cycle.
- **REQ:**
  - `imem_req` and `imem_addr` are held stable until ack.
  - On `imem_ack` with `FLUSH`=0: `INSTR`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, go to HOLD.
  - On `imem_ack` with `FLUSH`=1: data dropped, `imem_req`<=0, go to IDLE.
  - On `FLUSH` without ack: go to DROP; `imem_req` stays 1.
- **HOLD:**
  - `FLUSH` has priority over `dec_ready`: `instr_valid`<=0, not counted, go to IDLE.
  - Else if `dec_ready`: `fetch_count`<=`fetch_count`+1 (wraps mod 2^32), `instr_valid`<=0, `imem_addr`<=`IP`, `imem_req`<=1, go to REQ.
  - Else hold; `INSTR` is stable.
- **DROP:**
  - `imem_req` stays high until `imem_ack`.
  - On ack, data is discarded, `imem_req`<=0, go to IDLE.
  - `FLUSH` in DROP has no further effect.
- **`fetch_stall`** = NOT((state==IDLE AND `FLUSH`=0) OR (state==HOLD AND `dec_ready`=1 AND `FLUSH`=0)).
- **Timeout:**
  - The counter increments each cycle in REQ/DROP with `imem_ack`=0 and resets to 0 on ack or on leaving REQ/DROP.
  - When the counter reaches `TIMEOUT`: `fetch_err`<=1, `imem_req`<=0, `instr_valid`<=0, go to IDLE, counter cleared.
  - Fetching then resumes normally; `fetch_err` clears only on reset.
- `imem_ack` in IDLE or HOLD is ignored.
- `OP` always equals `INSTR[6:0]`; no other decode is done here.

## Timing
- Zero-wait memory (ack in first REQ cycle): `IP` sampled at edge N, `imem_req` high in cycle N+1, `instr_valid` high in cycle N+2.
- Steady-state throughput with `dec_ready`=1 and zero-wait memory: one instruction per 2 cycles.
- Each memory wait cycle adds one cycle of latency.
- A handoff in HOLD and the next request issue occur at the same edge. `IP` is sampled in the cycle where `fetch_stall`=0; the program counter advances at that same edge.
- `RESET`=0 at any edge overrides everything, including an outstanding request; `imem_req` drops in the following cycle and a late ack is ignored.

## Test plan
- **Reset then free-run:**
  - Stimulus: `RESET`=0 for 2 cycles; then release with `IP`=0x00, memory returns 0x00500093 with zero wait, `dec_ready`=1.
  - Response: `imem_addr`=0x00; `instr_valid` 2 cycles after release with `INSTR`=0x00500093, `OP`=0x13; `fetch_count`=1 after handoff.
- **Wait states:** ack 3 cycles after req -> `imem_req`/`imem_addr` stable 3 cycles, `fetch_stall`=1 throughout, `instr_valid` one cycle after ack.
- **Decode back-pressure:** `dec_ready`=0 for 4 cycles in HOLD -> `INSTR` unchanged, no new `imem_req`, `fetch_count` unchanged until `dec_ready`=1.
- **Flush mid-request:** `FLUSH` in REQ cycle 1, ack in cycle 3 with 0xDEADBEEF -> DROP, `instr_valid` stays 0, next request uses the post-flush `IP`=0x40.
- **Flush vs ready:** `FLUSH`=1 and `dec_ready`=1 together in HOLD -> instruction discarded, `fetch_count` not incremented, `instr_valid`=0.
- **Timeout:** `TIMEOUT`=4, no ack -> `fetch_err`=1 after 4 cycles, `imem_req`=0; next fetch proceeds; `fetch_err` clears only after `RESET`=0.
